// File: rtl/mxint_exp_pkg.sv
// Shared types and helpers for the MXINT block-exponent scheduler.
package mxint_exp_pkg;

  // Widest element the msb_index helper can handle; callers zero-extend into it.
  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic [0:0] {ACCUM, EMIT} state_t;

  function automatic int unsigned msb_index(input logic [MAX_WIDTH-1:0] v);
    msb_index = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (v[i]) msb_index = unsigned'(i);
    end
  endfunction

endpackage

// File: rtl/mxint_block_exp_sched_beat_abs_or.sv
// Per-beat datapath: absolute value of each signed element, OR-reduced across the beat.
module mxint_beat_abs_or #(
  parameter int unsigned IN_SIZE  = 2,
  parameter int unsigned IN_WIDTH = 32
) (
  input  logic [IN_SIZE*IN_WIDTH-1:0] data_in,
  output logic [IN_WIDTH-1:0]         beat_or
);

  always_comb begin
    logic [IN_WIDTH-1:0] elem;
    beat_or = '0;
    elem    = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      elem = data_in[i*IN_WIDTH +: IN_WIDTH];
      // Negating the most negative value wraps to 2^(W-1), which is the correct unsigned abs.
      if (elem[IN_WIDTH-1]) elem = ~elem + 1'b1;
      beat_or = beat_or | elem;
    end
  end

endmodule

// File: rtl/mxint_block_exp_sched.sv
// Multi-beat shared-exponent scheduler: emits floor(log2(max|x|)) once per block.
// Optional data_out_zero port enabled by defining MXINT_EXP_ZERO_FLAG_EN.
module mxint_block_exp_sched
  import mxint_exp_pkg::*;
#(
  parameter int unsigned IN_SIZE     = 2,
  parameter int unsigned IN_WIDTH    = 32,
  parameter int unsigned BLOCK_BEATS = 4,
  parameter int unsigned OUT_WIDTH   = $clog2(IN_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IN_SIZE*IN_WIDTH-1:0] data_in,
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic [OUT_WIDTH-1:0]        data_out,
  output logic                        data_out_valid,
  input  logic                        data_out_ready
`ifdef MXINT_EXP_ZERO_FLAG_EN
  ,
  output logic                        data_out_zero
`endif
);

  localparam int unsigned CntWidth = $clog2(BLOCK_BEATS) + 1;

  state_t              state;
  logic [CntWidth-1:0] beat_cnt;
  logic [IN_WIDTH-1:0] acc;
  logic [IN_WIDTH-1:0] beat_or;
  logic [IN_WIDTH-1:0] blk_or;
  logic                accept;
  logic                last_beat;

  mxint_beat_abs_or #(
    .IN_SIZE  (IN_SIZE),
    .IN_WIDTH (IN_WIDTH)
  ) u_beat_abs_or (
    .data_in (data_in),
    .beat_or (beat_or)
  );

  assign data_in_ready = (state == ACCUM) | ((state == EMIT) & data_out_ready);
  assign accept        = data_in_valid & data_in_ready;
  assign last_beat     = (beat_cnt == CntWidth'(BLOCK_BEATS - 1));
  assign blk_or        = acc | beat_or;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ACCUM;
      beat_cnt       <= '0;
      acc            <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
`ifdef MXINT_EXP_ZERO_FLAG_EN
      data_out_zero  <= 1'b0;
`endif
    end else begin
      if ((state == EMIT) && data_out_ready) begin
        state          <= ACCUM;
        data_out_valid <= 1'b0;
      end
      // A completing beat overrides the retire above, so BLOCK_BEATS==1 streams without bubbles.
      if (accept) begin
        if (last_beat) begin
          data_out       <= OUT_WIDTH'(msb_index(MAX_WIDTH'(blk_or)));
          data_out_valid <= 1'b1;
          acc            <= '0;
          beat_cnt       <= '0;
          state          <= EMIT;
`ifdef MXINT_EXP_ZERO_FLAG_EN
          data_out_zero  <= (blk_or == '0);
`endif
        end else begin
          acc      <= blk_or;
          beat_cnt <= beat_cnt + CntWidth'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mxint_block_exp_sched.sv
// Directed bench for mxint_block_exp_sched (IN_SIZE=2, IN_WIDTH=8, BLOCK_BEATS=3 and 1).
module tb_mxint_block_exp_sched;

  localparam int unsigned W  = 8;
  localparam int unsigned OW = 3;

  typedef struct {
    logic [2:0][15:0] beats;
    int               exp_out;
    int               exp_zero;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   din;
  logic          din_valid;
  logic          din_ready;
  logic [OW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [15:0]   din1;
  logic          din1_valid;
  logic          din1_ready;
  logic [OW-1:0] dout1;
  logic          dout1_valid;
  logic          dout1_ready;
`ifdef MXINT_EXP_ZERO_FLAG_EN
  logic          dzero;
  logic          dzero1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mxint_block_exp_sched #(
    .IN_SIZE     (2),
    .IN_WIDTH    (W),
    .BLOCK_BEATS (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (din),
    .data_in_valid  (din_valid),
    .data_in_ready  (din_ready),
    .data_out       (dout),
    .data_out_valid (dout_valid),
    .data_out_ready (dout_ready)
`ifdef MXINT_EXP_ZERO_FLAG_EN
    ,
    .data_out_zero  (dzero)
`endif
  );

  mxint_block_exp_sched #(
    .IN_SIZE     (2),
    .IN_WIDTH    (W),
    .BLOCK_BEATS (1)
  ) dut1 (
    .clk            (clk),
    .rst            (rst),
    .data_in        (din1),
    .data_in_valid  (din1_valid),
    .data_in_ready  (din1_ready),
    .data_out       (dout1),
    .data_out_valid (dout1_valid),
    .data_out_ready (dout1_ready)
`ifdef MXINT_EXP_ZERO_FLAG_EN
    ,
    .data_out_zero  (dzero1)
`endif
  );

  function automatic logic [15:0] bt(input int e0, input int e1);
    logic [7:0] a;
    logic [7:0] b;
    a = e0[7:0];
    b = e1[7:0];
    return {b, a};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{beats: {bt(2, 9),      bt(1, 0), bt(3, -5)},  exp_out: 3, exp_zero: 0};
    vecs[1] = '{beats: {bt(0, 0),      bt(0, 0), bt(0, 0)},   exp_out: 0, exp_zero: 1};
    vecs[2] = '{beats: {bt(0, 0),      bt(1, 1), bt(-128, 0)}, exp_out: 7, exp_zero: 0};
    vecs[3] = '{beats: {bt(0, 0),      bt(0, 0), bt(-1, 0)},  exp_out: 0, exp_zero: 0};
    vecs[4] = '{beats: {bt(0, 0),      bt(0, 16), bt(64, 32)}, exp_out: 6, exp_zero: 0};
    vecs[5] = '{beats: {bt(0, 0),      bt(0, 0), bt(-2, -3)}, exp_out: 1, exp_zero: 0};
    vecs[6] = '{beats: {bt(0, 0),      bt(0, 0), bt(127, -127)}, exp_out: 6, exp_zero: 0};

    rst = 1'b0;
    din = '0; din_valid = 1'b0; dout_ready = 1'b1;
    din1 = '0; din1_valid = 1'b0; dout1_ready = 1'b1;
    step();
    step();
    chk("reset_out", int'(dout), 0);
    chk("reset_valid", int'(dout_valid), 0);
    chk("reset_in_ready", int'(din_ready), 1);
`ifdef MXINT_EXP_ZERO_FLAG_EN
    chk("reset_zero", int'(dzero), 0);
`endif
    rst = 1'b1;
    step();

    // Table: one block per row, downstream always ready.
    for (int r = 0; r < 7; r++) begin
      dout_ready = 1'b1;
      din_valid  = 1'b1;
      for (int b = 0; b < 3; b++) begin
        din = vecs[r].beats[b];
        step();
        if (b < 2) chk($sformatf("row%0d_early_valid%0d", r, b), int'(dout_valid), 0);
      end
      din_valid = 1'b0;
      chk($sformatf("row%0d_valid", r), int'(dout_valid), 1);
      chk($sformatf("row%0d_exp", r), int'(dout), vecs[r].exp_out);
`ifdef MXINT_EXP_ZERO_FLAG_EN
      chk($sformatf("row%0d_zero", r), int'(dzero), vecs[r].exp_zero);
`endif
      step();
      chk($sformatf("row%0d_valid_drop", r), int'(dout_valid), 0);
    end

    // Back-pressure: exponent held, input stalled, then a beat taken on the retire cycle.
    din_valid = 1'b1;
    din = bt(3, 0); step();
    din = bt(0, 0); step();
    din = bt(0, 0);
    dout_ready = 1'b0;
    step();
    din = bt(64, 0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d_exp", k), int'(dout), 1);
      chk($sformatf("hold%0d_valid", k), int'(dout_valid), 1);
      chk($sformatf("hold%0d_in_ready", k), int'(din_ready), 0);
      step();
    end
    chk("hold_exit_in_ready", int'(din_ready), 0);
    dout_ready = 1'b1;
    #1;
    chk("retire_in_ready", int'(din_ready), 1);
    step();
    chk("retire_valid_drop", int'(dout_valid), 0);
    din = bt(0, 0); step();
    chk("overlap_mid_valid", int'(dout_valid), 0);
    step();
    din_valid = 1'b0;
    chk("overlap_valid", int'(dout_valid), 1);
    chk("overlap_exp", int'(dout), 6);
    step();

    // Mid-block reset discards the partial block.
    din_valid = 1'b1;
    din = bt(127, 0); step();
    step();
    din_valid = 1'b0;
    rst = 1'b0; step();
    rst = 1'b1;
    chk("midrst_valid", int'(dout_valid), 0);
    din_valid = 1'b1;
    din = bt(1, 0);
    step();
    chk("midrst_b0_valid", int'(dout_valid), 0);
    step();
    chk("midrst_b1_valid", int'(dout_valid), 0);
    step();
    din_valid = 1'b0;
    chk("midrst_valid_out", int'(dout_valid), 1);
    chk("midrst_exp", int'(dout), 0);
    step();

    // BLOCK_BEATS=1 full-rate streaming.
    din1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din1 = bt(1 << k, 0);
      step();
      chk($sformatf("stream%0d_valid", k), int'(dout1_valid), 1);
      chk($sformatf("stream%0d_exp", k), int'(dout1), k);
      chk($sformatf("stream%0d_in_ready", k), int'(din1_ready), 1);
    end
    din1_valid = 1'b0;
    step();
    chk("stream_valid_drop", int'(dout1_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
